mem_access_arbiter: RTL and testbench

Load/store front end for the 32-bit byte-addressable data memory (four 8-bit write-first banks, one-cycle synchronous read). Arbitrates between two requesters, port A (core MEM stage, priority) and port B (loader/debug), at one access per cycle. It converts RISC-V funct3 byte/half/word accesses into bank byte enables and lane-aligned write data, and sign- or zero-extends read data. It sits between the pipeline MEM stage and the memory instance, and drives the memory's byteEnable/addr/din and reads its dout.

---
 rtl/mem_access_arbiter_if.sv | 22 ++
 rtl/mem_access_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// Request/response bundle for one requester of the data-memory arbiter.
interface mem_req_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output valid, we, funct3, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, we, funct3, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-port load/store front end for a four-bank byte-enabled data memory:
// priority arbitration with starvation relief, lane alignment and load extension.
module mem_access_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_req_if.slave                 a,
    mem_req_if.slave                 b,
    output logic [3:0]               mem_byteEnable,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [31:0]              mem_din,
    input  logic [31:0]              mem_dout
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             grant_a, grant_b, granted;
    logic             sel_we;
    logic [2:0]       sel_f3;
    logic [31:0]      sel_addr, sel_wdata;
    logic [1:0]       off;
    logic             req_err;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_port_q, rsp_port_d;
    logic             rsp_load_q, rsp_load_d;
    logic [2:0]       rsp_f3_q, rsp_f3_d;
    logic [1:0]       rsp_off_q, rsp_off_d;
    logic             rsp_err_q, rsp_err_d;

    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      load_data;
    logic             rsp_live, rv_a, rv_b, rd_ok;

    // Grant, starvation tracking and granted-request mux
    always_comb begin
        grant_b   = b.valid && (!a.valid || (starve_q == CNT_W'(STARVE_LIMIT)));
        grant_a   = a.valid && !grant_b;
        granted   = (grant_a || grant_b) && !rst;
        a.ready   = grant_a && !rst;
        b.ready   = grant_b && !rst;
        starve_d  = (a.valid && b.valid && grant_a) ? starve_q + CNT_W'(1) : '0;
        sel_we    = grant_b ? b.we     : a.we;
        sel_f3    = grant_b ? b.funct3 : a.funct3;
        sel_addr  = grant_b ? b.addr   : a.addr;
        sel_wdata = grant_b ? b.wdata  : a.wdata;
        off       = sel_addr[1:0];
    end

    // Illegal funct3, store of an unsigned type, misalignment or address beyond the memory
    always_comb begin
        req_err = (sel_f3 == 3'b011) || (sel_f3[2:1] == 2'b11)
               || (sel_we && sel_f3[2])
               || ((sel_f3[1:0] == 2'b01) && sel_addr[0])
               || ((sel_f3[1:0] == 2'b10) && (off != 2'b00))
               || ((sel_addr >> (ADDRESS_WIDTH + 2)) != 32'd0);
    end

    // Memory-side drive: only legal stores ever assert byte enables
    always_comb begin
        mem_byteEnable = 4'b0000;
        mem_addr       = '0;
        mem_din        = '0;
        if (granted) begin
            mem_addr = sel_addr[ADDRESS_WIDTH+1:2];
            if (sel_we && !req_err) begin
                case (sel_f3[1:0])
                    2'b00: begin
                        mem_byteEnable = 4'b0001 << off;
                        mem_din        = {4{sel_wdata[7:0]}};
                    end
                    2'b01: begin
                        mem_byteEnable = 4'b0011 << off;
                        mem_din        = {2{sel_wdata[15:0]}};
                    end
                    default: begin
                        mem_byteEnable = 4'b1111;
                        mem_din        = sel_wdata;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rsp_valid_d = granted;
        rsp_port_d  = grant_b;
        rsp_load_d  = !sel_we;
        rsp_f3_d    = sel_f3;
        rsp_off_d   = off;
        rsp_err_d   = req_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_load_q  <= 1'b0;
            rsp_f3_q    <= 3'b000;
            rsp_off_q   <= 2'b00;
            rsp_err_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_load_q  <= rsp_load_d;
            rsp_f3_q    <= rsp_f3_d;
            rsp_off_q   <= rsp_off_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Response: select the addressed lane of the returning word and extend it
    always_comb begin
        lane_byte = mem_dout[{rsp_off_q, 3'b000} +: 8];
        lane_half = rsp_off_q[1] ? mem_dout[31:16] : mem_dout[15:0];
        case (rsp_f3_q[1:0])
            2'b00:   load_data = {{24{lane_byte[7] & ~rsp_f3_q[2]}}, lane_byte};
            2'b01:   load_data = {{16{lane_half[15] & ~rsp_f3_q[2]}}, lane_half};
            default: load_data = mem_dout;
        endcase
        rsp_live = rsp_valid_q && !rst;
        rv_a     = rsp_live && !rsp_port_q;
        rv_b     = rsp_live && rsp_port_q;
        rd_ok    = rsp_load_q && !rsp_err_q;
        a.rvalid = rv_a;
        b.rvalid = rv_b;
        a.err    = rv_a && rsp_err_q;
        b.err    = rv_b && rsp_err_q;
        a.rdata  = (rv_a && rd_ok) ? load_data : 32'd0;
        b.rdata  = (rv_b && rd_ok) ? load_data : 32'd0;
    end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: write-first banked memory stub, byte-level reference
// model checked every cycle, directed literal cases and randomized two-port traffic.
module tb_mem_access_arbiter;
    localparam int unsigned AW = 4;
    localparam int unsigned SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_req_if a_if ();
    mem_req_if b_if ();

    mem_access_arbiter #(.ADDRESS_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a_if),
        .b              (b_if),
        .mem_byteEnable (mem_be),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Memory instance stub: four write-first byte banks, one-cycle read
    logic [31:0] stub [16];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] din);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = din[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) stub[i] <= 32'd0;
            mem_dout <= 32'd0;
        end else begin
            stub[mem_addr] <= merge(stub[mem_addr], mem_be, mem_din);
            mem_dout       <= merge(stub[mem_addr], mem_be, mem_din);
        end
    end

    // Reference model: flat byte memory with plain size/alignment arithmetic
    logic [7:0] ref_mem [64];

    function automatic void model_access(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic err, output logic [31:0] rdata,
                                         output logic [3:0] be, output logic [31:0] din);
        int unsigned n;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4)
           || ((addr % 32'(n)) != 32'd0) || (addr >= 32'd64);
        rdata = 32'd0;
        be    = 4'd0;
        din   = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < int'(n); k++) ref_mem[6'(addr + 32'(k))] = wdata[8*k +: 8];
                be  = 4'(((32'd1 << n) - 32'd1) << addr[1:0]);
                din = (n == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                      (n == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
            end else begin
                v = 32'd0;
                for (int k = 0; k < int'(n); k++) v[8*k +: 8] = ref_mem[6'(addr + 32'(k))];
                if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                rdata = v;
            end
        end
    endfunction

    logic        p_valid, p_port, p_err;
    logic [31:0] p_rdata;
    int          m_starve;
    logic        a_took, b_took;
    logic        m_ga, m_gb, m_we, m_err;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_rdata, m_din;
    logic [3:0]  m_be;

    // Per-cycle compare of every DUT output against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_a_ready", 32'(a_if.ready), 32'd0);
            chk("rst_b_ready", 32'(b_if.ready), 32'd0);
            chk("rst_a_rvalid", 32'(a_if.rvalid), 32'd0);
            chk("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
            chk("rst_be", 32'(mem_be), 32'd0);
            p_valid  = 1'b0;
            p_port   = 1'b0;
            m_starve = 0;
            a_took   = 1'b0;
            b_took   = 1'b0;
            for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        end else begin
            m_gb = b_if.valid && (!a_if.valid || m_starve == int'(SL));
            m_ga = a_if.valid && !m_gb;
            chk("a_ready", 32'(a_if.ready), 32'(m_ga));
            chk("b_ready", 32'(b_if.ready), 32'(m_gb));
            chk("a_rvalid", 32'(a_if.rvalid), 32'(p_valid && !p_port));
            chk("b_rvalid", 32'(b_if.rvalid), 32'(p_valid && p_port));
            if (p_valid && !p_port) begin
                chk("a_err", 32'(a_if.err), 32'(p_err));
                chk("a_rdata", a_if.rdata, p_rdata);
            end
            if (p_valid && p_port) begin
                chk("b_err", 32'(b_if.err), 32'(p_err));
                chk("b_rdata", b_if.rdata, p_rdata);
            end
            if (m_ga || m_gb) begin
                m_we    = m_gb ? b_if.we     : a_if.we;
                m_f3    = m_gb ? b_if.funct3 : a_if.funct3;
                m_addr  = m_gb ? b_if.addr   : a_if.addr;
                m_wdata = m_gb ? b_if.wdata  : a_if.wdata;
                model_access(m_we, m_f3, m_addr, m_wdata, m_err, m_rdata, m_be, m_din);
                chk("mem_be", 32'(mem_be), 32'(m_be));
                chk("mem_addr", 32'(mem_addr), (m_addr >> 2) % 32'(1 << AW));
                if (m_we && !m_err) chk("mem_din", mem_din, m_din);
                p_valid = 1'b1;
                p_port  = m_gb;
                p_err   = m_err;
                p_rdata = m_rdata;
            end else begin
                chk("idle_be", 32'(mem_be), 32'd0);
                chk("idle_addr", 32'(mem_addr), 32'd0);
                chk("idle_din", mem_din, 32'd0);
                p_valid = 1'b0;
            end
            m_starve = (a_if.valid && b_if.valid && m_ga) ? m_starve + 1 : 0;
            a_took   = a_if.ready;
            b_took   = b_if.ready;
        end
    end

    task automatic issue_a(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic [3:0] exp_be,
                           input string nm);
        bit got;
        @(posedge clk); #1;
        a_if.we = we; a_if.funct3 = f3; a_if.addr = addr; a_if.wdata = wdata;
        a_if.valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (a_if.ready) begin
                got = 1'b1;
                chk({nm, "_be"}, 32'(mem_be), 32'(exp_be));
            end
        end
        if (!got) chk({nm, "_grant_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        a_if.valid = 1'b0;
        @(negedge clk);
        chk({nm, "_rvalid"}, 32'(a_if.rvalid), 32'd1);
        chk({nm, "_err"}, 32'(a_if.err), 32'(exp_err));
        chk({nm, "_rdata"}, a_if.rdata, exp_rdata);
    endtask

    task automatic rand_req(output logic we, output logic [2:0] f3,
                            output logic [31:0] addr, output logic [31:0] wdata);
        int unsigned r;
        we = 1'($urandom_range(0, 1));
        r  = $urandom_range(0, 9);
        case (r)
            0, 1:    f3 = 3'd0;
            2, 7:    f3 = 3'd1;
            3, 4:    f3 = 3'd2;
            5:       f3 = 3'd4;
            6:       f3 = 3'd5;
            8:       f3 = 3'($urandom_range(0, 7));
            default: f3 = 3'd2;
        endcase
        addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0)
            addr = addr & ~((f3[1:0] == 2'd0) ? 32'd0 : (f3[1:0] == 2'd1) ? 32'd1 : 32'd3);
        if ($urandom_range(0, 15) == 0) addr = $urandom;
        wdata = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        t_we;
        logic [2:0]  t_f3;
        logic [31:0] t_addr, t_wdata;

        rst = 1'b1;
        a_if.valid = 1'b0; a_if.we = 1'b0; a_if.funct3 = 3'd0; a_if.addr = 32'd0; a_if.wdata = 32'd0;
        b_if.valid = 1'b0; b_if.we = 1'b0; b_if.funct3 = 3'd0; b_if.addr = 32'd0; b_if.wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_a_rdata", a_if.rdata, 32'd0);
        chk("reset_b_rdata", b_if.rdata, 32'd0);
        chk("reset_a_err", 32'(a_if.err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        issue_a(1'b1, 3'b010, 32'h8, 32'h11223344, 1'b0, 32'h0, 4'b1111, "sw8");
        issue_a(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h11223344, 4'b0000, "lw8");
        issue_a(1'b1, 3'b000, 32'h9, 32'hAA, 1'b0, 32'h0, 4'b0010, "sb9");
        issue_a(1'b0, 3'b010, 32'h8, 32'h0, 1'b0, 32'h1122AA44, 4'b0000, "lw8_after_sb");
        issue_a(1'b1, 3'b010, 32'h4, 32'h80FF7F01, 1'b0, 32'h0, 4'b1111, "sw4");
        issue_a(1'b0, 3'b000, 32'h6, 32'h0, 1'b0, 32'hFFFFFFFF, 4'b0000, "lb6");
        issue_a(1'b0, 3'b100, 32'h6, 32'h0, 1'b0, 32'h000000FF, 4'b0000, "lbu6");
        issue_a(1'b0, 3'b001, 32'h6, 32'h0, 1'b0, 32'hFFFF80FF, 4'b0000, "lh6");
        issue_a(1'b0, 3'b101, 32'h4, 32'h0, 1'b0, 32'h00007F01, 4'b0000, "lhu4");
        issue_a(1'b0, 3'b000, 32'h4, 32'h0, 1'b0, 32'h00000001, 4'b0000, "lb4");
        issue_a(1'b1, 3'b001, 32'hE, 32'h1234, 1'b0, 32'h0, 4'b1100, "sh_e");
        issue_a(1'b0, 3'b001, 32'h5, 32'h0, 1'b1, 32'h0, 4'b0000, "lh5_err");
        issue_a(1'b1, 3'b010, 32'h2, 32'hDEADBEEF, 1'b1, 32'h0, 4'b0000, "sw2_err");
        issue_a(1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 32'h0, 4'b0000, "lw0_unchanged");
        issue_a(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, "f3_011_err");
        issue_a(1'b0, 3'b010, 32'h40, 32'h0, 1'b1, 32'h0, 4'b0000, "oob_err");
        issue_a(1'b1, 3'b100, 32'h0, 32'h55, 1'b1, 32'h0, 4'b0000, "sbu_err");

        // Continuous contention: AAAAB repeating
        @(posedge clk); #1;
        a_if.we = 1'b0; a_if.funct3 = 3'b010; a_if.addr = 32'h8; a_if.valid = 1'b1;
        b_if.we = 1'b0; b_if.funct3 = 3'b010; b_if.addr = 32'h4; b_if.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("arb_a", 32'(a_if.ready), 32'(i % 5 != 4));
            chk("arb_b", 32'(b_if.ready), 32'(i % 5 == 4));
        end
        @(posedge clk); #1;
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        repeat (2) @(posedge clk);

        // Back-to-back alternating stores/loads on A
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 8) begin
                a_if.we     = (i % 2 == 0);
                a_if.funct3 = 3'b010;
                a_if.addr   = 32'h10 + 32'(4 * (i / 2));
                a_if.wdata  = 32'hA5A50000 + 32'(i);
                a_if.valid  = 1'b1;
            end else begin
                a_if.valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) chk("pipe_rvalid", 32'(a_if.rvalid), 32'd1);
        end
        @(negedge clk);
        chk("pipe_rvalid_end", 32'(a_if.rvalid), 32'd0);

        // Reset right after a contested load grant clears response and starve count
        @(posedge clk); #1;
        a_if.we = 1'b0; a_if.funct3 = 3'b010; a_if.addr = 32'h8; a_if.valid = 1'b1;
        b_if.we = 1'b0; b_if.funct3 = 3'b010; b_if.addr = 32'h4; b_if.valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pre_rst_a", 32'(a_if.ready), 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_rvalid", 32'(a_if.rvalid), 32'd0);
        chk("rst_no_grant", 32'(a_if.ready | b_if.ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_grant", 32'(a_if.ready), 32'd1);
        chk("post_rst_b_grant", 32'(b_if.ready), 32'd0);
        chk("post_rst_rvalid", 32'(a_if.rvalid), 32'd0);
        @(posedge clk); #1;
        a_if.valid = 1'b0; b_if.valid = 1'b0;

        // Randomized two-port traffic honouring hold-until-ready
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (!a_if.valid || a_took) begin
                if ($urandom_range(0, 4) == 0) a_if.valid = 1'b0;
                else begin
                    rand_req(t_we, t_f3, t_addr, t_wdata);
                    a_if.we = t_we; a_if.funct3 = t_f3; a_if.addr = t_addr; a_if.wdata = t_wdata;
                    a_if.valid = 1'b1;
                end
            end
            if (!b_if.valid || b_took) begin
                if ($urandom_range(0, 4) == 0) b_if.valid = 1'b0;
                else begin
                    rand_req(t_we, t_f3, t_addr, t_wdata);
                    b_if.we = t_we; b_if.funct3 = t_f3; b_if.addr = t_addr; b_if.wdata = t_wdata;
                    b_if.valid = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        a_if.valid = 1'b0; b_if.valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
